win_framer: RTL and testbench

WIN_FRAMER -- requirements
Module: win_framer

---
 rtl/win_framer.sv | 153 +++++++++++++++
 tb/tb_win_framer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/win_framer.sv
// Overlapping-window framer: buffers decimated samples in a circular store and, every
// half frame once primed, streams the NFFT newest samples oldest-first multiplied by a tap table.
module win_framer #(
    parameter int unsigned IW             = 24,
    parameter int unsigned OW             = 24,
    parameter int unsigned TW             = 16,
    parameter int unsigned LGNFFT         = 10,
    parameter bit          OPT_FIXED_TAPS = 1'b0,
    parameter string       INITIAL_COEFFS = ""
) (
    input  logic                 i_clk,
    input  logic                 i_areset_n,
    input  logic                 i_tap_wr,
    input  logic [TW-1:0]        i_tap,
    input  logic                 i_ce,
    input  logic [IW-1:0]        i_sample,
    output logic                 o_ce,
    output logic                 o_frame,
    output logic [OW-1:0]        o_sample,
    output logic                 o_overflow
);

    localparam int unsigned NFFT = 1 << LGNFFT;
    localparam int unsigned PW   = IW + TW;
    localparam int unsigned NW   = PW - 1;
    localparam int unsigned DW   = NW - OW;
    // Fixed taps without a preload image would leave the table unusable, so keep the write port then.
    localparam bit TAP_WR_EN = !OPT_FIXED_TAPS || (INITIAL_COEFFS == "");

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t                 state_q, state_d;
    logic [LGNFFT-1:0]      rd_addr_q, rd_addr_d;
    logic [LGNFFT-1:0]      k_q, k_d;
    logic [LGNFFT-1:0]      wr_ptr_q;
    logic [LGNFFT-1:0]      tap_ptr_q;
    logic                   primed_q;
    logic                   prev_ce_q;
    logic                   v1_q, v2_q, v3_q;
    logic                   f1_q, f2_q, f3_q;
    logic                   o_ce_q, o_frame_q, ovf_q;
    logic [OW-1:0]          o_sample_q;

    logic [IW-1:0]          data_mem [NFFT];
    logic [TW-1:0]          tap_mem  [NFFT];
    logic signed [IW-1:0]   samp_q;
    logic signed [TW-1:0]   tap_q;
    logic signed [PW-1:0]   prod_q;
    logic [NW-1:0]          sum_q;

    logic                   trig_c;
    logic                   reading_c;
    logic [NW-1:0]          bias_c;

    // Frame trigger: completion of priming, then every half frame.
    assign trig_c    = i_ce && (primed_q ? (&wr_ptr_q[LGNFFT-2:0]) : (&wr_ptr_q));
    assign reading_c = (state_q == S_READ);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        k_d       = k_q;
        if (state_q == S_READ) begin
            rd_addr_d = rd_addr_q + LGNFFT'(1);
            k_d       = k_q + LGNFFT'(1);
            if (k_q == LGNFFT'(NFFT - 1)) begin
                state_d = S_IDLE;
            end
        end
        // A new trigger always restarts from its own oldest sample.
        if (trig_c) begin
            state_d   = S_READ;
            rd_addr_d = wr_ptr_q + LGNFFT'(1);
            k_d       = '0;
        end
    end

    // Convergent rounding bias: exact halves round towards an even kept LSB.
    always_comb begin
        bias_c = '0;
        bias_c = {{OW{1'b0}}, prod_q[DW], {(DW-1){~prod_q[DW]}}};
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            k_q        <= '0;
            wr_ptr_q   <= '0;
            tap_ptr_q  <= '0;
            primed_q   <= 1'b0;
            prev_ce_q  <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            f1_q       <= 1'b0;
            f2_q       <= 1'b0;
            f3_q       <= 1'b0;
            o_ce_q     <= 1'b0;
            o_frame_q  <= 1'b0;
            o_sample_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            k_q       <= k_d;
            prev_ce_q <= i_ce;
            if (i_ce) begin
                wr_ptr_q <= wr_ptr_q + LGNFFT'(1);
                if (&wr_ptr_q) begin
                    primed_q <= 1'b1;
                end
            end
            if (TAP_WR_EN && i_tap_wr) begin
                tap_ptr_q <= tap_ptr_q + LGNFFT'(1);
            end
            v1_q      <= reading_c;
            f1_q      <= reading_c && (k_q == '0);
            v2_q      <= v1_q;
            f2_q      <= f1_q;
            v3_q      <= v2_q;
            f3_q      <= f2_q;
            o_ce_q    <= v3_q;
            o_frame_q <= f3_q;
            if (v3_q) begin
                o_sample_q <= sum_q[NW-1:DW];
            end
            if (i_ce && prev_ce_q && reading_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage and arithmetic pipeline: read, multiply, round, (output register above).
    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            data_mem[wr_ptr_q] <= i_sample;
        end
        if (TAP_WR_EN && i_tap_wr) begin
            tap_mem[tap_ptr_q] <= i_tap;
        end
        samp_q <= data_mem[rd_addr_q];
        tap_q  <= tap_mem[k_q];
        prod_q <= PW'(samp_q) * PW'(tap_q);
        sum_q  <= prod_q[NW-1:0] + bias_c;
    end

    assign o_ce       = o_ce_q;
    assign o_frame    = o_frame_q;
    assign o_sample   = o_sample_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_win_framer.sv
// Scoreboard bench for win_framer with NFFT=8: directed frames with hand-computed windowed outputs.
module tb_win_framer;

    logic        clk;
    logic        rst_n;
    logic        tap_wr;
    logic [15:0] tap;
    logic        ce;
    logic [23:0] smp;
    logic        o_ce;
    logic        o_frame;
    logic [23:0] o_sample;
    logic        o_overflow;

    int total;
    int bad;

    typedef struct packed {
        logic [23:0] s;
        logic        f;
    } exp_t;

    exp_t exp_q[$];

    int e_ramp1 [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int e_ramp2 [8] = '{5, 6, 7, 8, 9, 10, 11, 12};
    int s_round [8] = '{3, 5, -3, 1, 7, -1, -5, 9};
    int e_round [8] = '{2, 2, -2, 0, 4, 0, -2, 4};
    int e_load1 [8] = '{'h00, 'h20, 'h40, 'h60, 'h80, 'hA0, 'hC0, 'hE0};
    int e_load2 [8] = '{'h000, 'h040, 'h080, 'h0C0, 'h100, 'h140, 'h180, 'h1C0};

    win_framer #(
        .IW(24), .OW(24), .TW(16), .LGNFFT(3), .OPT_FIXED_TAPS(1'b0), .INITIAL_COEFFS("")
    ) dut (
        .i_clk(clk),
        .i_areset_n(rst_n),
        .i_tap_wr(tap_wr),
        .i_tap(tap),
        .i_ce(ce),
        .i_sample(smp),
        .o_ce(o_ce),
        .o_frame(o_frame),
        .o_sample(o_sample),
        .o_overflow(o_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every presented output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && o_ce) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_o_ce got=%0d frame=%b want=no output", $signed(o_sample), o_frame);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_sample !== e.s || o_frame !== e.f) begin
                    bad++;
                    $display("FAIL out_sample got=%0d/frame=%b want=%0d/frame=%b",
                             $signed(o_sample), o_frame, $signed(e.s), e.f);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push_frame(input int vals [8]);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.s = 24'(vals[i]);
            e.f = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input int v);
        ce  = 1'b1;
        smp = 24'(v);
        @(posedge clk); #1;
        ce  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic write_taps(input int step, input bit ramp);
        for (int k = 0; k < 8; k++) begin
            tap_wr = 1'b1;
            tap    = ramp ? 16'(k * step) : 16'(step);
            @(posedge clk); #1;
        end
        tap_wr = 1'b0;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        chk("o_ce_idle", 32'(o_ce), 32'd0);
    endtask

    initial begin
        int n;
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        ce     = 1'b0;
        smp    = '0;
        tap_wr = 1'b0;
        tap    = '0;

        // Reset held with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            ce     = ~ce;
            smp    = 24'(i * 37 + 5);
            tap_wr = ~tap_wr;
            tap    = 16'(i * 911);
            #2;
            chk("rst_o_ce", 32'(o_ce), 32'd0);
            chk("rst_o_frame", 32'(o_frame), 32'd0);
            chk("rst_o_overflow", 32'(o_overflow), 32'd0);
            chk("rst_o_sample", 32'(o_sample), 32'd0);
        end
        ce     = 1'b0;
        tap_wr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Flat half-scale window, ramp input, then a 50% overlap frame.
        write_taps(16'h4000, 1'b0);
        push_frame(e_ramp1);
        for (int v = 2; v <= 16; v += 2) send(v);
        push_frame(e_ramp2);
        for (int v = 18; v <= 24; v += 2) send(v);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_o_sample", 32'(o_sample), 32'd12);

        // Round-half-to-even; taps survive reset, priming restarts.
        reset_pulse();
        push_frame(e_round);
        for (int i = 0; i < 8; i++) send(s_round[i]);
        drain();
        chk("no_overflow", 32'(o_overflow), 32'd0);

        // Ramp tap load, then a back-to-back i_ce during readout.
        reset_pulse();
        write_taps(16'h1000, 1'b1);
        push_frame(e_load1);
        for (int i = 0; i < 8; i++) send('h100);
        ce  = 1'b1;
        smp = 24'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ce  = 1'b0;
        chk("overflow_set", 32'(o_overflow), 32'd1);
        drain();
        repeat (10) @(posedge clk);
        #1;
        chk("overflow_sticky", 32'(o_overflow), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("overflow_cleared", 32'(o_overflow), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in the middle of a frame readout.
        push_frame(e_load1);
        for (int i = 0; i < 8; i++) send('h100);
        n = 0;
        while (exp_q.size() > 5 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_frame_reached", 32'(exp_q.size()), 32'd5);
        chk("mid_frame_o_ce", 32'(o_ce), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_o_ce", 32'(o_ce), 32'd0);
        chk("abort_o_sample", 32'(o_sample), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) send('h200);
        repeat (8) @(posedge clk);
        #1;
        chk("unprimed_quiet", 32'(o_ce), 32'd0);
        push_frame(e_load2);
        send('h200);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
